// File: rtl/memory_game_round_ctrl.sv
// Memory game round sequencer: LFSR pattern show, timed answer
// window, bit-reversed answer check, score/lives/round tracking.
module memory_game_round_ctrl #(
  parameter int SHOW_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int LIVES          = 3,
  parameter int MAX_ROUNDS     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [7:0] x,
  input  logic       submit,
  output logic [7:0] display,
  output logic [1:0] result,
  output logic [3:0] score,
  output logic [1:0] lives_left,
  output logic [3:0] round_num,
  output logic       busy,
  output logic       game_over,
  output logic       win
);

  localparam int TMAX =
    (SHOW_CYCLES > TIMEOUT_CYCLES) ?
    SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int TW =
    (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] SHOW_LD =
    TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LD =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LIVES_LD = 2'(LIVES);
  localparam logic [3:0] LAST_RND = 4'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW,
    WAIT,
    EVAL,
    DONE
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [7:0]    pattern;
  logic [7:0]    ans;
  logic [TW-1:0] timer;
  logic          tflag;

  logic          hit;
  logic [1:0]    lives_dec;

  function automatic logic [7:0] step(
    input logic [7:0] q
  );
    return {q[7] ^ q[0], q[7:1]};
  endfunction

  function automatic logic [7:0] bitrev(
    input logic [7:0] q
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = q[7-i];
    end
    return r;
  endfunction

  // Answer is judged against the mirrored pattern
  always_comb begin
    hit       = !tflag && (ans == bitrev(pattern));
    lives_dec = lives_left - 2'd1;
  end

  // Round sequencer with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= 8'h00;
      pattern    <= 8'h00;
      ans        <= 8'h00;
      timer      <= '0;
      tflag      <= 1'b0;
      display    <= 8'h00;
      result     <= 2'd0;
      score      <= 4'd0;
      lives_left <= 2'd0;
      round_num  <= 4'd0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      display <= (state == SHOW) ? pattern : 8'h00;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr       <= (seed == 8'h00) ?
                          8'h09 : seed;
            round_num  <= 4'd1;
            score      <= 4'd0;
            lives_left <= LIVES_LD;
            result     <= 2'd0;
            win        <= 1'b0;
            game_over  <= 1'b0;
            busy       <= 1'b1;
            state      <= GEN;
          end
        end
        GEN: begin
          lfsr    <= step(lfsr);
          pattern <= step(lfsr);
          timer   <= SHOW_LD;
          state   <= SHOW;
        end
        SHOW: begin
          if (timer == '0) begin
            timer <= WAIT_LD;
            state <= WAIT;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        WAIT: begin
          if (submit) begin
            ans   <= x;
            tflag <= 1'b0;
            state <= EVAL;
          end else if (timer == '0) begin
            tflag <= 1'b1;
            state <= EVAL;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        EVAL: begin
          if (hit) begin
            result <= 2'd2;
            if (score != 4'hf) begin
              score <= score + 4'd1;
            end
          end else begin
            result     <= 2'd1;
            lives_left <= lives_dec;
          end
          if (!hit && lives_dec == 2'd0) begin
            win       <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b1;
            state     <= DONE;
          end else if (round_num == LAST_RND) begin
            win       <= 1'b1;
            busy      <= 1'b0;
            game_over <= 1'b1;
            state     <= DONE;
          end else begin
            round_num <= round_num + 4'd1;
            state     <= GEN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_game_round_ctrl.sv
// Bench for memory_game_round_ctrl: directed steps plus random
// rounds checked against a behavioural game model.
`timescale 1ns/1ps
module tb_memory_game_round_ctrl;

  localparam int S  = 16;
  localparam int T  = 64;
  localparam int MR = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] seed;
  logic [7:0] x;
  logic       submit;
  logic [7:0] display;
  logic [1:0] result;
  logic [3:0] score;
  logic [1:0] lives_left;
  logic [3:0] round_num;
  logic       busy;
  logic       game_over;
  logic       win;

  logic       start2;
  logic [7:0] seed2;
  logic [7:0] x2;
  logic       submit2;
  logic [7:0] display2;
  logic [1:0] result2;
  logic [3:0] score2;
  logic [1:0] lives2;
  logic [3:0] round2;
  logic       busy2;
  logic       over2;
  logic       win2;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_lfsr;
  int         m_score;
  int         m_lives;
  int         m_round;
  int         m_result;
  bit         m_done;
  bit         m_win;
  logic [7:0] last_disp;

  always #5 clk = ~clk;

  memory_game_round_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .x          (x),
    .submit     (submit),
    .display    (display),
    .result     (result),
    .score      (score),
    .lives_left (lives_left),
    .round_num  (round_num),
    .busy       (busy),
    .game_over  (game_over),
    .win        (win)
  );

  memory_game_round_ctrl #(.MAX_ROUNDS(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .seed       (seed2),
    .x          (x2),
    .submit     (submit2),
    .display    (display2),
    .result     (result2),
    .score      (score2),
    .lives_left (lives2),
    .round_num  (round2),
    .busy       (busy2),
    .game_over  (over2),
    .win        (win2)
  );

  function automatic logic [7:0] ref_step(
    input logic [7:0] q
  );
    int v;
    int fb;
    v  = int'(q);
    fb = ((v >> 7) ^ v) & 1;
    return 8'((v >> 1) + fb * 128);
  endfunction

  function automatic logic [7:0] ref_rev(
    input logic [7:0] q
  );
    int v;
    int r;
    v = int'(q);
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if (((v >> i) & 1) == 1) r += 1 << (7 - i);
    end
    return 8'(r);
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".result"}, 32'(result),
        32'(m_result));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
    chk({tag, ".lives"}, 32'(lives_left),
        32'(m_lives));
    chk({tag, ".round"}, 32'(round_num),
        32'(m_round));
    chk({tag, ".busy"}, 32'(busy),
        m_done ? 32'd0 : 32'd1);
    chk({tag, ".over"}, 32'(game_over),
        m_done ? 32'd1 : 32'd0);
    chk({tag, ".win"}, 32'(win),
        m_win ? 32'd1 : 32'd0);
  endtask

  task automatic start_game(input logic [7:0] s);
    seed  = s;
    start = 1'b1;
    tick;
    start    = 1'b0;
    m_lfsr   = (s == 8'h00) ? 8'h09 : s;
    m_round  = 1;
    m_score  = 0;
    m_lives  = 3;
    m_result = 0;
    m_done   = 0;
    m_win    = 0;
    check_status("start");
  endtask

  // mode 0 correct, 1 wrong, 2 timeout, 3 submit xv
  task automatic play_round(
    input int         mode,
    input int         d,
    input logic [7:0] xv
  );
    logic [7:0] pat;
    logic [7:0] exp_ans;
    logic [7:0] xs;
    int         cnt;
    int         nwait;
    bit         hit;
    m_lfsr  = ref_step(m_lfsr);
    pat     = m_lfsr;
    exp_ans = ref_rev(pat);
    tick;
    chk("gen_disp", 32'(display), 0);
    cnt = 0;
    repeat (S) begin
      tick;
      if (display === pat) cnt++;
    end
    last_disp = display;
    chk("show_len", 32'(cnt), 32'(S));
    nwait = (mode == 2) ? T : d;
    for (int k = 0; k < nwait; k++) begin
      tick;
      if (k == 0) chk("wait_disp", 32'(display), 0);
    end
    xs = 8'h00;
    if (mode != 2) begin
      case (mode)
        0:       xs = exp_ans;
        1:       xs = exp_ans ^
                      8'(1 << $urandom_range(7));
        default: xs = xv;
      endcase
      x      = xs;
      submit = 1'b1;
      tick;
      submit = 1'b0;
    end
    chk("eval_disp", 32'(display), 0);
    chk("res_hold", 32'(result), 32'(m_result));
    tick;
    hit = (mode != 2) && (xs == exp_ans);
    if (hit) begin
      m_result = 2;
      if (m_score < 15) m_score++;
    end else begin
      m_result = 1;
      m_lives--;
    end
    if (m_lives == 0) begin
      m_done = 1;
      m_win  = 0;
    end else if (m_round == MR) begin
      m_done = 1;
      m_win  = 1;
    end else begin
      m_round++;
    end
    check_status("eval");
  endtask

  task automatic play_random_game;
    start_game(8'($urandom_range(255)));
    while (!m_done) begin
      play_round($urandom_range(2),
                 $urandom_range(T - 1), 8'h00);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p2;
    reset   = 1'b0;
    start   = 1'b0;
    seed    = 8'h00;
    x       = 8'h00;
    submit  = 1'b0;
    start2  = 1'b0;
    seed2   = 8'h00;
    x2      = 8'h00;
    submit2 = 1'b0;
    repeat (2) tick;
    chk("rst.display", 32'(display), 0);
    chk("rst.result", 32'(result), 0);
    chk("rst.score", 32'(score), 0);
    chk("rst.lives", 32'(lives_left), 0);
    chk("rst.round", 32'(round_num), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.over", 32'(game_over), 0);
    chk("rst.win", 32'(win), 0);
    reset = 1'b1;
    tick;

    start_game(8'h09);
    play_round(3, 5, 8'h21);
    chk("r1_pat", 32'(last_disp), 32'h84);
    chk("r1_res", 32'(result), 2);
    chk("r1_score", 32'(score), 1);
    chk("r1_round", 32'(round_num), 2);
    play_round(3, 0, 8'h43);
    chk("r2_pat", 32'(last_disp), 32'hc2);
    chk("r2_score", 32'(score), 2);

    tick;
    repeat (4) tick;
    #2 reset = 1'b0;
    #1;
    chk("arst.display", 32'(display), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.score", 32'(score), 0);
    chk("arst.round", 32'(round_num), 0);
    chk("arst.result", 32'(result), 0);
    tick;
    tick;
    reset = 1'b1;
    tick;
    chk("idle.round", 32'(round_num), 0);
    chk("idle.busy", 32'(busy), 0);
    chk("idle.over", 32'(game_over), 0);

    start_game(8'h00);
    play_round(3, 10, 8'h84);
    chk("s0_pat", 32'(last_disp), 32'h84);
    chk("s0_res", 32'(result), 1);
    chk("s0_lives", 32'(lives_left), 2);
    chk("s0_score", 32'(score), 0);
    chk("s0_round", 32'(round_num), 2);
    play_round(3, T - 1, ref_rev(ref_step(m_lfsr)));
    chk("late_sub", 32'(result), 2);
    while (!m_done) begin
      play_round($urandom_range(2),
                 $urandom_range(T - 1), 8'h00);
    end
    submit = 1'b1;
    x      = 8'h00;
    repeat (5) tick;
    submit = 1'b0;
    check_status("done_hold");

    start_game(8'($urandom_range(255)));
    repeat (3) play_round(2, 0, 8'h00);
    chk("to.lives", 32'(lives_left), 0);
    chk("to.over", 32'(game_over), 1);
    chk("to.win", 32'(win), 0);
    chk("to.round", 32'(round_num), 3);
    chk("to.result", 32'(result), 1);
    start_game(8'($urandom_range(255)));
    chk("relaunch.round", 32'(round_num), 1);
    chk("relaunch.lives", 32'(lives_left), 3);
    while (!m_done) begin
      play_round($urandom_range(2),
                 $urandom_range(T - 1), 8'h00);
    end
    repeat (2) play_random_game();

    seed2  = 8'h5a;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    p2     = 8'h5a;
    for (int r = 0; r < 2; r++) begin
      p2      = ref_step(p2);
      start2  = 1'b1;
      seed2   = 8'h00;
      submit2 = 1'b1;
      x2      = ~ref_rev(p2);
      repeat (1 + S) tick;
      start2  = 1'b0;
      x2      = ref_rev(p2);
      tick;
      submit2 = 1'b0;
      tick;
      chk("d2.result", 32'(result2), 2);
      chk("d2.score", 32'(score2), 32'(r + 1));
    end
    chk("d2.over", 32'(over2), 1);
    chk("d2.win", 32'(win2), 1);
    chk("d2.lives", 32'(lives2), 3);
    chk("d2.round", 32'(round2), 2);
    chk("d2.busy", 32'(busy2), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
